seg_scroll_ctrl: RTL and testbench
==================================

Name: seg_scroll_ctrl

Overview:
- Sequences a message of 5-bit display codes onto NUM_DIGITS seven-segment decoders, either statically or as a timed right-to-left scroll.
- Outputs one code per digit; each code drives one seven_seg instance.
- Sits between the top-level application logic (score, status or error text) and the HEX display decoders.
- Owns message capture, scroll timing, the wrap gap, and the illegal-length error display.

Parameters:
- NUM_DIGITS, 4: number of physical displays driven.
- MAX_LEN, 16: maximum message length in codes.
- TICK_DIV, 25000000: clk cycles per scroll step; legal range 2 to 2^26.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- load  input  1  request to capture a new message; honoured only while ready=1.
- mode  input  1  sampled with load: 0 = static, 1 = scroll.
- msg_len  input  5  number of valid codes, 1..MAX_LEN.
- msg_data  input  MAX_LEN*5  flattened codes; code 0 is in bits [4:0].
- pause  input  1  while high, freezes the scroll divider and position.
- ready  output  1  high when a load can be accepted.
- busy  output  1  high in SCROLL state.
- err  output  1  high while the error message is displayed.
- wrap_done  output  1  one-cycle pulse when the scroll position wraps to 0.
- digit_codes  output  NUM_DIGITS*5  digit 0 (leftmost) occupies the MSBs.

Behaviour:
- Code space: values 0-15 are hex digits 0-F. BLANK, E and R are the shared display code constants.
- Reset (asynchronous, any state):
  - state = IDLE; all digits BLANK.
  - ready=1, busy=0, err=0, wrap_done=0.
  - Position and divider = 0; message buffer cleared to BLANK.
- States: IDLE, CAPTURE, STATIC, SCROLL, ERROR.
- ready is 1 in every state except CAPTURE.
- load sampled high with ready=1 at edge k → state CAPTURE:
  - msg_data, msg_len and mode are registered.
  - Position and divider are cleared.
  - ready=0 for the cycle after edge k.
- Edge k+1, leaving CAPTURE:
  - msg_len==0 or msg_len>MAX_LEN → ERROR. Digits show E,R,R,BLANK (remaining digits BLANK if NUM_DIGITS>4); err=1.
  - Otherwise mode=0 → STATIC; mode=1 → SCROLL.
  - digit_codes reflect the new content after edge k+1 (2-cycle load-to-display latency).
- STATIC display:
  - digit i shows buf[i] if i < len, else BLANK.
  - No timing activity; wrap_done never pulses.
- SCROLL display:
  - Virtual sequence is buf[0..len-1] followed by NUM_DIGITS BLANKs; period P = len + NUM_DIGITS.
  - digit i shows seq[(pos+i) mod P].
  - Divider counts 0..TICK_DIV-1 while pause=0.
  - At terminal count: divider → 0 and pos → pos+1 mod P.
  - When pos goes P-1 → 0, wrap_done is high for exactly the following cycle.
- pause=1: divider, pos and digit_codes hold; state is unchanged. Deasserting pause resumes from the held divider value.
- Simultaneous events:
  - load accepted in the same cycle as a terminal tick: the load wins, no pos advance, no wrap_done.
  - load with pause=1: the load is accepted; the new scroll stays frozen at pos 0 until pause=0.
- A new load is accepted from STATIC, SCROLL or ERROR and fully replaces the prior message. err clears on exit from ERROR.
- Only the first len codes of msg_data are used; unused buffer entries are stored as BLANK.
- Reset asserted mid-scroll returns to IDLE immediately. No pulse is emitted on reset release.
- busy=1 only in SCROLL.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst mid-cycle → all digits BLANK, ready=1, busy=0, err=0 asynchronously. Release → outputs hold.
- Static: load, mode=0, len=3, codes 1,2,3 → after 2 edges digits = 1,2,3,BLANK; busy=0; no wrap_done over 100 cycles.
- Scroll: TICK_DIV=4, mode=1, len=5, codes C,A,F,E,1 (12,10,15,14,1).
  - Initial digits C,A,F,E; every 4 cycles one step left.
  - Step 2 shows F,E,1,BLANK.
  - After 9 steps, digits return to C,A,F,E with a single wrap_done pulse.
- Pause: during the scroll, hold pause 10 cycles mid-divider → digits frozen. After release, the next step comes after the remaining divider count, not a full period.
- Error: load with len=0, then len=17 → digits E,R,R,BLANK, err=1. A valid load then clears err.
- Collision: assert load on the divider terminal cycle → pos=0 after capture, no wrap_done, ready low exactly one cycle. A load asserted while ready=0 is ignored.

Source files
------------

// File: rtl/seg_scroll_if.sv
// Message-load / display bundle between application logic and seg_scroll_ctrl.
// The application side is the master; the scroll controller is the slave.
interface seg_scroll_if #(
    parameter int NUM_DIGITS = 4,
    parameter int MAX_LEN    = 16
);
    logic                    load;
    logic                    mode;
    logic [4:0]              msg_len;
    logic [MAX_LEN*5-1:0]    msg_data;
    logic                    pause;
    logic                    ready;
    logic                    busy;
    logic                    err;
    logic                    wrap_done;
    logic [NUM_DIGITS*5-1:0] digit_codes;

    modport master (
        output load, mode, msg_len, msg_data, pause,
        input  ready, busy, err, wrap_done, digit_codes
    );

    modport slave (
        input  load, mode, msg_len, msg_data, pause,
        output ready, busy, err, wrap_done, digit_codes
    );
endinterface

// File: rtl/seg_scroll_ctrl.sv
// Captures a message of 5-bit display codes and presents it on NUM_DIGITS
// seven-segment decoders, statically or as a timed right-to-left scroll.
module seg_scroll_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int MAX_LEN    = 16,
    parameter int TICK_DIV   = 25000000
) (
    input logic         clk,
    input logic         rst,
    seg_scroll_if.slave bus
);

    localparam logic [4:0] CODE_E     = 5'd14;
    localparam logic [4:0] CODE_R     = 5'd16;
    localparam logic [4:0] CODE_BLANK = 5'd31;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_STATIC  = 3'd2;
    localparam logic [2:0] S_SCROLL  = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;

    localparam int DIV_W = $clog2(TICK_DIV);
    // pos + digit index can reach almost twice the period before the wrap fix-up
    localparam int POS_W = $clog2(2 * (MAX_LEN + NUM_DIGITS));
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [2:0]              state, state_n;
    logic [4:0]              len_q;
    logic                    mode_q;
    logic [4:0]              msg_buf [MAX_LEN];
    logic [POS_W-1:0]        pos, pos_n;
    logic [DIV_W-1:0]        div, div_n;
    logic                    ready_q, busy_q, err_q, wrap_q, wrap_n;
    logic [NUM_DIGITS*5-1:0] digits_q, digits_n;

    logic                    accept;
    logic                    len_bad;
    logic [POS_W-1:0]        per;
    logic [POS_W-1:0]        j;
    logic [4:0]              digit;

    assign accept  = bus.load && ready_q;
    assign len_bad = (len_q == 5'd0) || (32'(len_q) > MAX_LEN);
    assign per     = POS_W'(len_q) + POS_W'(NUM_DIGITS);

    always_comb begin
        // NOTE: every variable gets a default up front so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_n  = state;
        pos_n    = pos;
        div_n    = div;
        wrap_n   = 1'b0;
        digits_n = digits_q;
        j        = '0;
        digit    = CODE_BLANK;

        if (accept) begin
            state_n = S_CAPTURE;
            pos_n   = '0;
            div_n   = '0;
        end else begin
            case (state)
                S_CAPTURE: state_n = len_bad ? S_ERROR : (mode_q ? S_SCROLL : S_STATIC);
                S_SCROLL: begin
                    if (!bus.pause) begin
                        if (div == DIV_W'(TICK_DIV - 1)) begin
                            div_n = '0;
                            if (pos == per - POS_W'(1)) begin
                                pos_n  = '0;
                                wrap_n = 1'b1;
                            end else begin
                                pos_n = pos + POS_W'(1);
                            end
                        end else begin
                            div_n = div + DIV_W'(1);
                        end
                    end
                end
                default: state_n = state;
            endcase
        end

        // Static mode is the scroll window frozen at position 0.
        for (int i = 0; i < NUM_DIGITS; i++) begin
            j     = pos_n + POS_W'(i);
            digit = CODE_BLANK;
            if (j >= per)
                j = j - per;
            case (state_n)
                S_CAPTURE: digit = digits_q[(NUM_DIGITS-1-i)*5 +: 5];
                S_ERROR:   digit = (i == 0) ? CODE_E : ((i < 3) ? CODE_R : CODE_BLANK);
                S_STATIC, S_SCROLL:
                    if (j < POS_W'(len_q))
                        digit = msg_buf[j[IDX_W-1:0]];
                default:   digit = CODE_BLANK;
            endcase
            digits_n[(NUM_DIGITS-1-i)*5 +: 5] = digit;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            mode_q   <= 1'b0;
            pos      <= '0;
            div      <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
            digits_q <= {NUM_DIGITS{CODE_BLANK}};
            // NOTE: the buffer is small register storage, not a RAM macro, so
            // clearing it on reset is cheap and keeps its contents defined.
            for (int i = 0; i < MAX_LEN; i++)
                msg_buf[i] <= CODE_BLANK;
        end else begin
            state    <= state_n;
            pos      <= pos_n;
            div      <= div_n;
            ready_q  <= (state_n != S_CAPTURE);
            busy_q   <= (state_n == S_SCROLL);
            err_q    <= (state_n == S_ERROR);
            wrap_q   <= wrap_n;
            digits_q <= digits_n;
            if (accept) begin
                len_q  <= bus.msg_len;
                mode_q <= bus.mode;
                for (int i = 0; i < MAX_LEN; i++)
                    msg_buf[i] <= (32'(bus.msg_len) > i) ? bus.msg_data[i*5 +: 5] : CODE_BLANK;
            end
        end
    end

    assign bus.ready       = ready_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;
    assign bus.wrap_done   = wrap_q;
    assign bus.digit_codes = digits_q;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Directed and randomized bench for seg_scroll_ctrl, checked every cycle
// against a time-based reference model of the display.
module tb_seg_scroll_ctrl;

    localparam int ND = 4;
    localparam int ML = 16;
    localparam int TD = 4;

    localparam logic [4:0] C_BLANK = 5'd31;
    localparam logic [4:0] C_E     = 5'd14;
    localparam logic [4:0] C_R     = 5'd16;

    localparam int K_IDLE = 0, K_STATIC = 1, K_SCROLL = 2, K_ERR = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scroll_if #(.NUM_DIGITS(ND), .MAX_LEN(ML)) bus ();

    seg_scroll_ctrl #(.NUM_DIGITS(ND), .MAX_LEN(ML), .TICK_DIV(TD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what is shown, and how many unpaused scroll cycles elapsed.
    int         m_kind;
    int         m_len;
    logic [4:0] m_codes [ML];
    bit         m_pending;
    int         m_act;
    bit         m_wrap;
    int         k_len;
    bit         k_mode;
    logic [4:0] k_codes [ML];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ND*5-1:0] exp_digits();
        logic [ND*5-1:0] d;
        logic [4:0]      c;
        int              per, pos, jj;
        per = m_len + ND;
        pos = (m_kind == K_SCROLL) ? (m_act / TD) % per : 0;
        for (int i = 0; i < ND; i++) begin
            c = C_BLANK;
            if (m_kind == K_ERR)
                c = (i == 0) ? C_E : ((i < 3) ? C_R : C_BLANK);
            else if (m_kind != K_IDLE) begin
                jj = (pos + i) % per;
                if (jj < m_len) c = m_codes[jj];
            end
            d[(ND-1-i)*5 +: 5] = c;
        end
        return d;
    endfunction

    task automatic model_reset();
        m_kind = K_IDLE; m_len = 0; m_pending = 0; m_act = 0; m_wrap = 0;
    endtask

    task automatic model_edge();
        if (bus.load && !m_pending) begin
            m_pending = 1;
            k_len  = int'(bus.msg_len);
            k_mode = bus.mode;
            for (int i = 0; i < ML; i++) k_codes[i] = bus.msg_data[i*5 +: 5];
            m_wrap = 0;
        end else if (m_pending) begin
            m_pending = 0;
            m_act  = 0;
            m_wrap = 0;
            if (k_len == 0 || k_len > ML) m_kind = K_ERR;
            else begin
                m_kind  = k_mode ? K_SCROLL : K_STATIC;
                m_len   = k_len;
                m_codes = k_codes;
            end
        end else if (m_kind == K_SCROLL && !bus.pause) begin
            m_act++;
            m_wrap = (m_act % (TD * (m_len + ND)) == 0);
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic check_all();
        check("ready",  64'(bus.ready),       64'(!m_pending));
        check("busy",   64'(bus.busy),        64'(m_kind == K_SCROLL && !m_pending));
        check("err",    64'(bus.err),         64'(m_kind == K_ERR && !m_pending));
        check("wrap",   64'(bus.wrap_done),   64'(m_wrap));
        check("digits", 64'(bus.digit_codes), 64'(exp_digits()));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [ML*5-1:0] mk(input int n, input int c0, input int c1,
                                           input int c2, input int c3, input int c4);
        logic [ML*5-1:0] d;
        int              c [5];
        c = '{c0, c1, c2, c3, c4};
        for (int i = 0; i < ML; i++) d[i*5 +: 5] = 5'($urandom);
        for (int i = 0; i < n && i < 5; i++) d[i*5 +: 5] = 5'(c[i]);
        return d;
    endfunction

    task automatic load_msg(input bit md, input logic [4:0] len, input logic [ML*5-1:0] data);
        bus.mode = md; bus.msg_len = len; bus.msg_data = data; bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
        cycle();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_digits", 64'(bus.digit_codes), 64'({ND{C_BLANK}}));
        check("rst_ready",  64'(bus.ready), 64'(1));
        check("rst_busy",   64'(bus.busy), 64'(0));
        check("rst_err",    64'(bus.err), 64'(0));
        check("rst_wrap",   64'(bus.wrap_done), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cycle();
    endtask

    int wraps;

    initial begin
        rst = 1'b1;
        bus.load = 1'b0; bus.mode = 1'b0; bus.msg_len = '0; bus.msg_data = '0; bus.pause = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) cycle();
        async_reset();

        // Static message, then a long idle stretch with no wrap pulses.
        load_msg(1'b0, 5'd3, mk(3, 1, 2, 3, 0, 0));
        check("static_digits", 64'(bus.digit_codes), 64'({5'd1, 5'd2, 5'd3, C_BLANK}));
        repeat (100) cycle();

        // Scroll C,A,F,E,1 with a 4-cycle step; period is 9 positions.
        load_msg(1'b1, 5'd5, mk(5, 12, 10, 15, 14, 1));
        check("scroll_init", 64'(bus.digit_codes), 64'({5'd12, 5'd10, 5'd15, 5'd14}));
        repeat (8) cycle();
        check("scroll_step2", 64'(bus.digit_codes), 64'({5'd15, 5'd14, 5'd1, C_BLANK}));
        wraps = 0;
        repeat (28) begin
            cycle();
            if (bus.wrap_done) wraps++;
        end
        check("scroll_wraps", 64'(wraps), 64'(1));
        check("scroll_back", 64'(bus.digit_codes), 64'({5'd12, 5'd10, 5'd15, 5'd14}));

        // Pause mid-divider; the next step must use the remaining count.
        repeat (2) cycle();
        bus.pause = 1'b1;
        repeat (10) cycle();
        check("pause_frozen", 64'(bus.digit_codes), 64'({5'd12, 5'd10, 5'd15, 5'd14}));
        bus.pause = 1'b0;
        cycle();
        check("resume_early", 64'(bus.digit_codes), 64'({5'd12, 5'd10, 5'd15, 5'd14}));
        cycle();
        check("resume_step", 64'(bus.digit_codes), 64'({5'd10, 5'd15, 5'd14, 5'd1}));

        // Illegal lengths, then a legal load clears the error.
        load_msg(1'b0, 5'd0, mk(0, 0, 0, 0, 0, 0));
        check("err_len0", 64'(bus.err), 64'(1));
        check("err_digits0", 64'(bus.digit_codes), 64'({C_E, C_R, C_R, C_BLANK}));
        load_msg(1'b1, 5'd17, mk(0, 0, 0, 0, 0, 0));
        check("err_len17", 64'(bus.err), 64'(1));
        check("err_digits17", 64'(bus.digit_codes), 64'({C_E, C_R, C_R, C_BLANK}));
        load_msg(1'b0, 5'd2, mk(2, 5, 6, 0, 0, 0));
        check("err_clear", 64'(bus.err), 64'(0));
        check("err_new_digits", 64'(bus.digit_codes), 64'({5'd5, 5'd6, C_BLANK, C_BLANK}));

        // Load on the divider terminal cycle, held into the CAPTURE cycle.
        load_msg(1'b1, 5'd2, mk(2, 7, 8, 0, 0, 0));
        repeat (3) cycle();
        bus.mode = 1'b1; bus.msg_len = 5'd3; bus.msg_data = mk(3, 9, 10, 11, 0, 0);
        bus.load = 1'b1;
        cycle();
        check("collide_ready_low", 64'(bus.ready), 64'(0));
        cycle();
        bus.load = 1'b0;
        check("collide_ready_high", 64'(bus.ready), 64'(1));
        check("collide_wrap", 64'(bus.wrap_done), 64'(0));
        check("collide_pos0", 64'(bus.digit_codes), 64'({5'd9, 5'd10, 5'd11, C_BLANK}));
        repeat (6) cycle();
        async_reset();

        // Randomized traffic: sparse loads of any length, toggling pause.
        for (int n = 0; n < 3000; n++) begin
            bus.load = ($urandom % 60) == 0;
            bus.mode = 1'($urandom);
            bus.msg_len = 5'($urandom_range(0, 18));
            bus.msg_data = mk(0, 0, 0, 0, 0, 0);
            if (($urandom % 25) == 0) bus.pause = ~bus.pause;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
